sram_arbiter: RTL and testbench

- Shares the single SRAM interface block between two bus masters: port 0 (68000 CPU) and port 1 (DMA/video fetch).
- Sequences each access on the memory side: drive the strobes, wait for the memory acknowledge, drop the strobes, then return the acknowledge and read data to the requester.
- Two-way round-robin arbitration, plus a cycle timeout so a stuck access cannot hang the bus.

---
 rtl/sram_arbiter.sv | 155 +++++++++++++++
 tb/tb_sram_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single SRAM interface.
// Sequences strobe/ack handshakes and aborts accesses that never complete.
module sram_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_rw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_uds,
  input  logic              m0_lds,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_rw,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_uds,
  input  logic              m1_lds,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_uds,
  output logic              mem_lds,
  output logic              mem_rw,
  input  logic              mem_ack,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, RELEASE, DONE
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [7:0]          cnt;
  logic                err_flag;
  logic                grant, gport, tmo;
  logic                ack_port, go_done;
  logic [ADDR_W-1:0]   s_addr;
  logic [DATA_W-1:0]   s_wdata;
  logic                s_rw, s_uds, s_lds;

  // Request selection and next-state decode
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    tmo       = 1'b0;
    gport     = (m0_req && m1_req) ? ~owner : m1_req;
    s_addr    = gport ? m1_addr  : m0_addr;
    s_wdata   = gport ? m1_wdata : m0_wdata;
    s_rw      = gport ? m1_rw    : m0_rw;
    s_uds     = gport ? m1_uds   : m0_uds;
    s_lds     = gport ? m1_lds   : m0_lds;
    unique case (state)
      IDLE: begin
        if (!mem_ack && (m0_req || m1_req)) begin
          grant     = 1'b1;
          state_nxt = (s_uds || s_lds) ? ISSUE : DONE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (mem_ack) begin
          state_nxt = RELEASE;
        end else if (cnt == TMO_LAST) begin
          tmo       = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    ack_port = (state == IDLE) ? gport : owner;
    go_done  = (state_nxt == DONE) && (state != DONE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Memory-side registers, completion pulses and read data
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_uds   <= 1'b0;
      mem_lds   <= 1'b0;
      mem_rw    <= 1'b1;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      busy      <= 1'b0;
      owner     <= 1'b1;
      cnt       <= '0;
      err_flag  <= 1'b0;
    end else begin
      busy   <= (state_nxt != IDLE);
      m0_ack <= go_done && !ack_port;
      m1_ack <= go_done &&  ack_port;
      m0_err <= go_done && !ack_port && err_flag;
      m1_err <= go_done &&  ack_port && err_flag;
      unique case (state)
        IDLE: begin
          if (grant) begin
            owner     <= gport;
            mem_addr  <= s_addr;
            mem_wdata <= s_wdata;
            mem_rw    <= s_rw;
            mem_uds   <= s_uds;
            mem_lds   <= s_lds;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (mem_ack) begin
            if (mem_rw && !owner) m0_rdata <= mem_rdata;
            if (mem_rw &&  owner) m1_rdata <= mem_rdata;
          end else begin
            cnt <= cnt + 8'd1;
            if (tmo) begin
              err_flag <= 1'b1;
              if (mem_rw && !owner) m0_rdata <= '1;
              if (mem_rw &&  owner) m1_rdata <= '1;
            end
          end
        end
        RELEASE: begin
          mem_uds <= 1'b0;
          mem_lds <= 1'b0;
          mem_rw  <= 1'b1;
        end
        DONE:    err_flag <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed vector table, round-robin sequence,
// reset-abort sequence and random traffic against a transaction model.
module tb_sram_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_rw, m0_uds, m0_lds;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m0_ack, m0_err;
  logic          m1_req, m1_rw, m1_uds, m1_lds;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          m1_ack, m1_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_uds, mem_lds, mem_rw;
  logic          mem_ack = 1'b0;
  logic          busy, owner;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr),
    .m0_uds(m0_uds), .m0_lds(m0_lds), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr),
    .m1_uds(m1_uds), .m1_lds(m1_lds), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_uds(mem_uds), .mem_lds(mem_lds),
    .mem_rw(mem_rw), .mem_ack(mem_ack),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    bit            rw;
    logic [AW-1:0] addr;
    bit            uds;
    bit            lds;
    logic [DW-1:0] wdata;
    int            dly;
    int            lat;
    bit            err;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  // SRAM interface model: acks dly cycles after strobes appear
  logic [DW-1:0] smem [logic [AW-1:0]];
  int dly = 0;
  int scnt = 0;
  always @(posedge clk) begin
    logic [DW-1:0] w;
    if (reset || !(mem_uds || mem_lds)) begin
      mem_ack <= 1'b0;
      scnt    <= 0;
    end else if (!mem_ack) begin
      if (scnt == dly) begin
        mem_ack <= 1'b1;
        w = smem.exists(mem_addr) ? smem[mem_addr] : init_word(mem_addr);
        if (mem_rw) begin
          mem_rdata <= w;
        end else begin
          if (mem_uds) w[15:8] = mem_wdata[15:8];
          if (mem_lds) w[7:0]  = mem_wdata[7:0];
          smem[mem_addr] = w;
        end
      end else begin
        scnt <= scnt + 1;
      end
    end
  end

  // Reference model: memory contents and per-port read data
  logic [DW-1:0] rmem [logic [AW-1:0]];
  logic [DW-1:0] ref_rd [2];

  function automatic logic [DW-1:0] ref_word(logic [AW-1:0] a);
    return rmem.exists(a) ? rmem[a] : init_word(a);
  endfunction

  task automatic ref_update(vec_t v);
    logic [DW-1:0] w;
    bit active;
    active = v.uds || v.lds;
    if (!active) return;
    if (v.rw) begin
      ref_rd[v.port] = v.err ? 16'hFFFF : ref_word(v.addr);
    end else if (!v.err) begin
      w = ref_word(v.addr);
      if (v.uds) w[15:8] = v.wdata[15:8];
      if (v.lds) w[7:0]  = v.wdata[7:0];
      rmem[v.addr] = w;
    end
  endtask

  function automatic vec_t expect_of(vec_t v);
    vec_t r = v;
    if (!(v.uds || v.lds)) begin
      r.lat = 1; r.err = 1'b0;
    end else if (v.dly <= TO - 1) begin
      r.lat = 4 + v.dly; r.err = 1'b0;
    end else begin
      r.lat = 3 + TO; r.err = 1'b1;
    end
    return r;
  endfunction

  // Expected memory-side fields while strobes are active
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0;
  bit cur_rw = 1'b1, cur_uds = 1'b0, cur_lds = 1'b0;

  task automatic set_cur(vec_t v);
    cur_addr = v.addr; cur_wdata = v.wdata; cur_rw = v.rw;
    cur_uds = v.uds;   cur_lds = v.lds;     dly = v.dly;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("dual_ack", {31'b0, m0_ack & m1_ack}, 32'd0);
      if (mem_uds || mem_lds) begin
        chk("mem_strobes", {mem_uds, mem_lds}, {cur_uds, cur_lds});
        chk("mem_addr", mem_addr, cur_addr);
        chk("mem_rw", mem_rw, cur_rw);
        if (!cur_rw) chk("mem_wdata", mem_wdata, cur_wdata);
      end
    end
  end

  task automatic drive(int p, bit rq, vec_t v);
    if (p == 0) begin
      m0_req = rq; m0_rw = v.rw; m0_addr = v.addr;
      m0_uds = v.uds; m0_lds = v.lds; m0_wdata = v.wdata;
    end else begin
      m1_req = rq; m1_rw = v.rw; m1_addr = v.addr;
      m1_uds = v.uds; m1_lds = v.lds; m1_wdata = v.wdata;
    end
  endtask

  task automatic set_req(int p, bit rq);
    if (p == 0) m0_req = rq;
    else        m1_req = rq;
  endtask

  task automatic scramble(int p);
    vec_t s;
    s.port = p; s.rw = 1'($urandom); s.addr = AW'($urandom);
    s.uds = 1'($urandom); s.lds = 1'($urandom); s.wdata = DW'($urandom);
    s.dly = 0; s.lat = 0; s.err = 0;
    drive(p, 1'b1, s);
  endtask

  task automatic do_reset();
    vec_t z;
    z = '{0, 1'b1, '0, 1'b0, 1'b0, '0, 0, 0, 1'b0};
    reset = 1'b1;
    drive(0, 1'b0, z);
    drive(1, 1'b0, z);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ref_rd[0] = '0;
    ref_rd[1] = '0;
  endtask

  task automatic do_txn(vec_t v);
    int n;
    bit got;
    logic my_ack, my_err, ot_ack, ot_err;
    set_cur(v);
    drive(v.port, 1'b1, v);
    n = 0;
    got = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) scramble(v.port);
      if ((v.port == 0) ? m0_ack : m1_ack) got = 1;
    end
    my_ack = (v.port == 0) ? m0_ack : m1_ack;
    my_err = (v.port == 0) ? m0_err : m1_err;
    ot_ack = (v.port == 0) ? m1_ack : m0_ack;
    ot_err = (v.port == 0) ? m1_err : m0_err;
    chk("ack_seen", got, 1);
    chk("latency", n, v.lat);
    chk("ack_other", ot_ack, 0);
    chk("err", my_err, v.err);
    chk("err_other", ot_err, 0);
    ref_update(v);
    chk("m0_rdata", m0_rdata, ref_rd[0]);
    chk("m1_rdata", m1_rdata, ref_rd[1]);
    set_req(v.port, 1'b0);
    @(negedge clk);
    chk("ack_single", my_ack & ((v.port == 0) ? m0_ack : m1_ack), 0);
  endtask

  vec_t tbl [10];

  initial begin
    vec_t a, b, v;
    int n;
    int ep;

    tbl[0] = '{1, 1'b0, 20'h00010, 1'b1, 1'b1, 16'hBEEF, 0,   4,  1'b0};
    tbl[1] = '{0, 1'b1, 20'h00010, 1'b1, 1'b1, 16'h0000, 1,   5,  1'b0};
    tbl[2] = '{1, 1'b0, 20'h00003, 1'b1, 1'b0, 16'h12AB, 0,   4,  1'b0};
    tbl[3] = '{0, 1'b1, 20'h00003, 1'b1, 1'b1, 16'h0000, 3,   7,  1'b0};
    tbl[4] = '{0, 1'b1, 20'h00010, 1'b1, 1'b1, 16'h0000, 255, 18, 1'b1};
    tbl[5] = '{0, 1'b1, 20'h00011, 1'b0, 1'b0, 16'h0000, 0,   1,  1'b0};
    tbl[6] = '{1, 1'b1, 20'h00010, 1'b1, 1'b1, 16'h0000, 14,  18, 1'b0};
    tbl[7] = '{1, 1'b0, 20'h00005, 1'b1, 1'b1, 16'h7777, 255, 18, 1'b1};
    tbl[8] = '{1, 1'b1, 20'h00005, 1'b1, 1'b1, 16'h0000, 0,   4,  1'b0};
    tbl[9] = '{0, 1'b0, 20'h00012, 1'b0, 1'b0, 16'h9999, 0,   1,  1'b0};

    do_reset();
    @(negedge clk);
    chk("rst_owner", owner, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mem_rw", mem_rw, 1);
    chk("rst_strobes", {mem_uds, mem_lds}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);

    // Both ports requesting from reset: strict alternation from port 0
    a = '{0, 1'b1, 20'h00020, 1'b1, 1'b1, 16'h0000, 0, 4, 1'b0};
    b = '{1, 1'b0, 20'h00021, 1'b1, 1'b1, 16'hA5A5, 0, 4, 1'b0};
    set_cur(a);
    drive(0, 1'b1, a);
    drive(1, 1'b1, b);
    for (int i = 0; i < 4; i++) begin
      ep = i % 2;
      n = 0;
      while (!(m0_ack || m1_ack) && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("rr_ack_port", {m1_ack, m0_ack}, (ep == 1) ? 2'b10 : 2'b01);
      chk("rr_owner", owner, ep);
      ref_update((ep == 0) ? a : b);
      chk("rr_m0_rdata", m0_rdata, ref_rd[0]);
      set_req(ep, 1'b0);
      @(negedge clk);
      chk("rr_ack_single", {m0_ack, m1_ack}, 0);
      if (i < 3) set_cur((ep == 0) ? b : a);
      if (i < 2) set_req(ep, 1'b1);
    end
    repeat (2) @(negedge clk);

    foreach (tbl[i]) do_txn(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      v.port  = int'($urandom_range(0, 1));
      v.rw    = 1'($urandom);
      v.addr  = AW'($urandom_range(0, 7));
      v.uds   = ($urandom_range(0, 3) != 0);
      v.lds   = ($urandom_range(0, 3) != 0);
      v.wdata = DW'($urandom);
      v.dly   = ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 9));
      v = expect_of(v);
      do_txn(v);
    end

    // Reset while an access is stuck waiting for mem_ack
    v = '{0, 1'b1, 20'h00007, 1'b1, 1'b1, 16'h0000, 255, 18, 1'b1};
    set_cur(v);
    drive(0, 1'b1, v);
    repeat (5) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_strobes", {mem_uds, mem_lds}, 2'b11);
    reset = 1'b1;
    m0_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_strobes", {mem_uds, mem_lds}, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ack", {m0_ack, m0_err}, 0);
    reset = 1'b0;
    ref_rd[0] = '0;
    ref_rd[1] = '0;
    @(negedge clk);
    chk("post_rst_ack", {m0_ack, m1_ack}, 0);
    chk("post_rst_rdata", m0_rdata, 0);
    v = '{0, 1'b1, 20'h00007, 1'b1, 1'b1, 16'h0000, 2, 6, 1'b0};
    do_txn(v);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
